// File: rtl/move_detector.sv
// rtl/move_detector.sv - debounced board occupancy tracker and lift/place move decoder
module move_detector #(
  parameter int STABLE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] layout,
  input  logic        layout_valid,
  output logic        move_valid,
  output logic [5:0]  from_sq,
  output logic [5:0]  to_sq,
  output logic        capture,
  output logic        error,
  output logic [63:0] board
);

  localparam int CW = $clog2(STABLE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_SCANS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LIFT1,
    S_LIFT2,
    S_ERR
  } state_t;

  // Debounce storage
  logic [63:0]   candidate;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          reached;

  // Accepted snapshot, frozen together with its one-cycle pulse
  logic          acc_pulse;
  logic [63:0]   acc;

  // Move tracking state
  state_t        state;
  state_t        state_n;
  logic [5:0]    from_r;
  logic [5:0]    from_n;
  logic [5:0]    cap_r;
  logic [5:0]    cap_n;
  logic [63:0]   board_n;

  // Report produced by the decision logic, registered onto the outputs
  logic          rep;
  logic [5:0]    rep_to;
  logic          rep_cap;

  // Difference terms between committed board and accepted snapshot
  logic [63:0]   rem;
  logic [63:0]   add;
  logic [63:0]   from_bit;
  logic [63:0]   cap_bit;
  logic [63:0]   rem_other;
  logic          rem_none;
  logic          add_none;
  logic          add_one;
  logic          rem_one;
  logic          other_one;

  function automatic logic is_one_hot(input logic [63:0] v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

  // Lowest set bit position; callers only use it on one-hot values
  function automatic logic [5:0] bit_index(input logic [63:0] v);
    logic [5:0] idx;
    idx = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) idx = 6'(i);
    end
    return idx;
  endfunction

  assign cnt_inc   = cnt + CNT_ONE;
  assign rem       = board & ~acc;
  assign add       = ~board & acc;
  assign from_bit  = 64'd1 << from_r;
  assign cap_bit   = 64'd1 << cap_r;
  assign rem_other = rem & ~from_bit;
  assign rem_none  = (rem == 64'd0);
  assign add_none  = (add == 64'd0);
  assign add_one   = is_one_hot(add);
  assign rem_one   = is_one_hot(rem);
  assign other_one = is_one_hot(rem_other);

  // Count consecutive identical snapshots; flag the scan that completes a run
  always_ff @(posedge clk) begin
    if (reset) begin
      candidate <= 64'd0;
      cnt       <= '0;
      reached   <= 1'b0;
    end else begin
      reached <= 1'b0;
      if (layout_valid) begin
        if (layout == candidate) begin
          if (cnt != CNT_MAX) begin
            cnt     <= cnt_inc;
            reached <= (cnt_inc == CNT_MAX);
          end
        end else begin
          candidate <= layout;
          cnt       <= CNT_ONE;
          reached   <= (CNT_ONE == CNT_MAX);
        end
      end
    end
  end

  // Turn a completed run into the accept pulse and hold the snapshot it refers to
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_pulse <= 1'b0;
      acc       <= 64'd0;
    end else begin
      acc_pulse <= reached;
      if (reached) acc <= candidate;
    end
  end

  // Decide the next tracking state and any move report for an accepted snapshot
  always_comb begin
    state_n = state;
    board_n = board;
    from_n  = from_r;
    cap_n   = cap_r;
    rep     = 1'b0;
    rep_to  = cap_r;
    rep_cap = 1'b0;
    if (acc_pulse) begin
      case (state)
        S_INIT: begin
          board_n = acc;
          state_n = S_IDLE;
        end
        S_IDLE: begin
          if (rem_none && add_none) begin
            state_n = S_IDLE;
          end else if (rem_one && add_none) begin
            from_n  = bit_index(rem);
            state_n = S_LIFT1;
          end else begin
            state_n = S_ERR;
          end
        end
        S_LIFT1: begin
          if (acc == board) begin
            state_n = S_IDLE;
          end else if ((rem == from_bit) && add_none) begin
            state_n = S_LIFT1;
          end else if ((rem == from_bit) && add_one) begin
            rep     = 1'b1;
            rep_to  = bit_index(add);
            rep_cap = 1'b0;
            board_n = acc;
            state_n = S_IDLE;
          end else if (((rem & from_bit) != 64'd0) && other_one && add_none) begin
            cap_n   = bit_index(rem_other);
            state_n = S_LIFT2;
          end else begin
            state_n = S_ERR;
          end
        end
        S_LIFT2: begin
          if ((rem == (from_bit | cap_bit)) && add_none) begin
            state_n = S_LIFT2;
          end else if ((rem == from_bit) && add_none) begin
            // Captured square is occupied again, now by the moving piece
            rep     = 1'b1;
            rep_to  = cap_r;
            rep_cap = 1'b1;
            board_n = acc;
            state_n = S_IDLE;
          end else if (acc == board) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_ERR;
          end
        end
        S_ERR: begin
          if (acc == board) state_n = S_IDLE;
        end
        default: begin
          state_n = S_INIT;
        end
      endcase
    end
  end

  // Register tracking state, committed board and the move report outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_INIT;
      board      <= 64'd0;
      from_r     <= 6'd0;
      cap_r      <= 6'd0;
      move_valid <= 1'b0;
      from_sq    <= 6'd0;
      to_sq      <= 6'd0;
      capture    <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      board      <= board_n;
      from_r     <= from_n;
      cap_r      <= cap_n;
      move_valid <= rep;
      error      <= (state_n == S_ERR);
      if (rep) begin
        from_sq <= from_r;
        to_sq   <= rep_to;
        capture <= rep_cap;
      end
    end
  end

endmodule

// File: tb/tb_move_detector.sv
// tb/tb_move_detector.sv - self-checking bench for move_detector with snapshot-level model
module tb_move_detector;

  localparam int N = 2;
  localparam logic [63:0] S = 64'hFFFF_0000_0000_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] layout;
  logic        layout_valid;
  logic        move_valid;
  logic [5:0]  from_sq;
  logic [5:0]  to_sq;
  logic        capture;
  logic        error;
  logic [63:0] board;

  int errors = 0;
  int checks = 0;

  // Outputs observed around one scan
  logic        o_pre, o_mv, o_post, o_cap, o_err;
  logic [5:0]  o_from, o_to;
  logic [63:0] o_board;

  // Reference model: snapshot history plus a move interpreter on board sets
  logic [63:0] hist[$];
  int          mphase;
  logic [63:0] mboard;
  int          mfrom, mcap;
  logic        e_mv, e_cap, e_err;
  int          e_from, e_to;

  move_detector #(.STABLE_SCANS(N)) dut (
    .clk(clk), .reset(reset), .layout(layout), .layout_valid(layout_valid),
    .move_valid(move_valid), .from_sq(from_sq), .to_sq(to_sq),
    .capture(capture), .error(error), .board(board)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [63:0] v);
    for (int i = 0; i < 64; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    mphase = 0; mboard = 64'd0; mfrom = 0; mcap = 0;
    e_mv = 1'b0; e_from = 0; e_to = 0; e_cap = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_report(input int f, input int t, input logic c);
    e_mv = 1'b1; e_from = f; e_to = t; e_cap = c;
  endtask

  // phase: 0 init, 1 idle, 2 one piece lifted, 3 two pieces lifted, 4 error
  task automatic model_accept(input logic [63:0] a);
    logic [63:0] rem, add, fb, cb;
    int nr, na;
    rem = mboard & ~a; add = ~mboard & a;
    nr = $countones(rem); na = $countones(add);
    fb = 64'd1 << mfrom; cb = 64'd1 << mcap;
    case (mphase)
      0: begin mboard = a; mphase = 1; end
      1: begin
        if (nr == 0 && na == 0) mphase = 1;
        else if (nr == 1 && na == 0) begin mfrom = lowest(rem); mphase = 2; end
        else mphase = 4;
      end
      2: begin
        if (a == mboard) mphase = 1;
        else if (rem == fb && na == 0) mphase = 2;
        else if (rem == fb && na == 1) begin
          model_report(mfrom, lowest(add), 1'b0); mboard = a; mphase = 1;
        end else if (rem[mfrom] && nr == 2 && na == 0) begin
          mcap = lowest(rem & ~fb); mphase = 3;
        end else mphase = 4;
      end
      3: begin
        if (rem == (fb | cb) && na == 0) mphase = 3;
        else if (rem == fb && na == 0) begin
          model_report(mfrom, mcap, 1'b1); mboard = a; mphase = 1;
        end else if (a == mboard) mphase = 1;
        else mphase = 4;
      end
      default: if (a == mboard) mphase = 1;
    endcase
    e_err = (mphase == 4);
  endtask

  task automatic model_scan(input logic [63:0] l);
    int run;
    e_mv = 1'b0;
    hist.push_back(l);
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == l) run++;
      else break;
    end
    if (run == N) model_accept(l);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; layout_valid = 1'b0; layout = 64'd0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One scan: pulse layout_valid, then observe one, two and three cycles after sampling
  task automatic send_scan(input logic [63:0] l);
    model_scan(l);
    @(negedge clk);
    layout = l; layout_valid = 1'b1;
    @(negedge clk);
    layout_valid = 1'b0;
    @(negedge clk);
    o_pre = move_valid;
    @(negedge clk);
    o_mv = move_valid; o_from = from_sq; o_to = to_sq; o_cap = capture;
    o_err = error; o_board = board;
    @(negedge clk);
    o_post = move_valid;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({move_valid, capture, error} !== 3'b000) begin errors++;
      $display("FAIL reset_flags: got %b expected 000", {move_valid, capture, error}); end
    checks++; if ({from_sq, to_sq} !== 12'd0) begin errors++;
      $display("FAIL reset_squares: got %0d/%0d expected 0/0", from_sq, to_sq); end
    checks++; if (board !== 64'd0) begin errors++;
      $display("FAIL reset_board: got %h expected 0", board); end
    send_scan(S);
    checks++; if (o_board !== 64'd0) begin errors++;
      $display("FAIL init_first_scan_board: got %h expected 0", o_board); end
    send_scan(S);
    checks++; if (o_board !== S) begin errors++;
      $display("FAIL init_load_board: got %h expected %h", o_board, S); end
    checks++; if ({o_pre, o_mv, o_post, o_err} !== 4'b0000) begin errors++;
      $display("FAIL init_no_pulse: got %b expected 0000", {o_pre, o_mv, o_post, o_err}); end
  endtask

  task automatic test_simple_move();
    logic [63:0] l1, l2;
    int pulses;
    l1 = S & ~(64'd1 << 8);
    l2 = l1 | (64'd1 << 24);
    pulses = 0;
    send_scan(l1); pulses += o_mv;
    send_scan(l1); pulses += o_mv;
    send_scan(l2); pulses += o_mv;
    send_scan(l2); pulses += o_mv;
    checks++; if (pulses !== 1) begin errors++;
      $display("FAIL move_pulse_count: got %0d expected 1", pulses); end
    checks++; if ({o_pre, o_mv, o_post} !== 3'b010) begin errors++;
      $display("FAIL move_pulse_timing: got %b expected 010", {o_pre, o_mv, o_post}); end
    checks++; if ({o_from, o_to, o_cap} !== {6'd8, 6'd24, 1'b0}) begin errors++;
      $display("FAIL move_report: got %0d->%0d cap=%b expected 8->24 cap=0", o_from, o_to, o_cap); end
    checks++; if (o_board !== l2) begin errors++;
      $display("FAIL move_board: got %h expected %h", o_board, l2); end
  endtask

  task automatic test_capture();
    logic [63:0] b, l1, l2;
    int pulses;
    b  = S & ~(64'd1 << 8) | (64'd1 << 24);
    l1 = b & ~(64'd1 << 24);
    l2 = l1 & ~(64'd1 << 49);
    pulses = 0;
    send_scan(l1); pulses += o_mv;
    send_scan(l1); pulses += o_mv;
    send_scan(l2); pulses += o_mv;
    send_scan(l2); pulses += o_mv;
    send_scan(l1); pulses += o_mv;
    send_scan(l1); pulses += o_mv;
    checks++; if (pulses !== 1 || o_mv !== 1'b1) begin errors++;
      $display("FAIL capture_pulse: got count=%0d last=%b expected 1/1", pulses, o_mv); end
    checks++; if ({o_from, o_to, o_cap} !== {6'd24, 6'd49, 1'b1}) begin errors++;
      $display("FAIL capture_report: got %0d->%0d cap=%b expected 24->49 cap=1", o_from, o_to, o_cap); end
    checks++; if (o_board !== (S & ~(64'd1 << 8))) begin errors++;
      $display("FAIL capture_board: got %h expected %h", o_board, S & ~(64'd1 << 8)); end
  endtask

  task automatic test_bounce();
    logic [63:0] saved;
    saved = S & ~(64'd1 << 8);
    for (int i = 0; i < 10; i++) begin
      send_scan((i % 2 == 0) ? S : (S ^ 64'd1));
      checks++; if ({o_pre, o_mv, o_post} !== 3'b000) begin errors++;
        $display("FAIL bounce_pulse[%0d]: got %b expected 000", i, {o_pre, o_mv, o_post}); end
      checks++; if (o_board !== saved) begin errors++;
        $display("FAIL bounce_board[%0d]: got %h expected %h", i, o_board, saved); end
    end
  endtask

  task automatic test_error();
    logic [63:0] x, l1, l2;
    do_reset();
    send_scan(S); send_scan(S);
    x = S | (64'd1 << 20) | (64'd1 << 21);
    send_scan(x);
    checks++; if (o_err !== 1'b0) begin errors++;
      $display("FAIL error_early: got %b expected 0", o_err); end
    send_scan(x);
    checks++; if (o_err !== 1'b1 || o_mv !== 1'b0) begin errors++;
      $display("FAIL error_set: got err=%b mv=%b expected 1/0", o_err, o_mv); end
    send_scan(S);
    checks++; if (o_err !== 1'b1) begin errors++;
      $display("FAIL error_held: got %b expected 1", o_err); end
    send_scan(S);
    checks++; if (o_err !== 1'b0 || o_board !== S) begin errors++;
      $display("FAIL error_clear: got err=%b board=%h expected 0/%h", o_err, o_board, S); end
    l1 = S & ~64'd1;
    l2 = l1 | (64'd1 << 16);
    send_scan(l1); send_scan(l1); send_scan(l2); send_scan(l2);
    checks++; if ({o_mv, o_from, o_to, o_cap} !== {1'b1, 6'd0, 6'd16, 1'b0}) begin errors++;
      $display("FAIL error_then_move: got mv=%b %0d->%0d cap=%b expected 1 0->16 cap=0", o_mv, o_from, o_to, o_cap); end
  endtask

  task automatic test_reset_midseq();
    logic [63:0] t;
    t = (S & ~64'd1 | (64'd1 << 16)) & ~(64'd1 << 16);
    send_scan(t); send_scan(t);
    do_reset();
    checks++; if ({move_valid, capture, error, from_sq, to_sq} !== 15'd0 || board !== 64'd0) begin errors++;
      $display("FAIL midseq_reset: got mv=%b cap=%b err=%b %0d->%0d board=%h expected all 0",
               move_valid, capture, error, from_sq, to_sq, board); end
    send_scan(t);
    send_scan(t);
    checks++; if (o_board !== t || o_mv !== 1'b0 || o_err !== 1'b0) begin errors++;
      $display("FAIL midseq_reload: got board=%h mv=%b err=%b expected %h/0/0", o_board, o_mv, o_err, t); end
  endtask

  task automatic test_random();
    logic [63:0] cur, l;
    int kind, reps;
    do_reset();
    send_scan(S); send_scan(S);
    cur = S;
    for (int it = 0; it < 120; it++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4)      l = cur & ~(64'd1 << $urandom_range(0, 63));
      else if (kind < 7) l = cur | (64'd1 << $urandom_range(0, 63));
      else if (kind < 8) l = mboard;
      else               l = cur ^ (64'd1 << $urandom_range(0, 63)) ^ (64'd1 << $urandom_range(0, 63));
      reps = $urandom_range(1, 3);
      for (int r = 0; r < reps; r++) begin
        send_scan(l);
        checks++; if ({o_pre, o_mv, o_post} !== {1'b0, e_mv, 1'b0}) begin errors++;
          $display("FAIL rand_pulse[%0d]: got %b expected 0%b0", it, {o_pre, o_mv, o_post}, e_mv); end
        checks++; if (o_board !== mboard || o_err !== e_err) begin errors++;
          $display("FAIL rand_state[%0d]: got board=%h err=%b expected %h/%b", it, o_board, o_err, mboard, e_err); end
        checks++; if (o_from !== 6'(e_from) || o_to !== 6'(e_to) || o_cap !== e_cap) begin errors++;
          $display("FAIL rand_report[%0d]: got %0d->%0d cap=%b expected %0d->%0d cap=%b",
                   it, o_from, o_to, o_cap, e_from, e_to, e_cap); end
      end
      cur = l;
    end
  endtask

  initial begin
    reset = 1'b1; layout = 64'd0; layout_valid = 1'b0;
    test_reset();
    test_simple_move();
    test_capture();
    test_bounce();
    test_error();
    test_reset_midseq();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
